// File: rtl/drive_sequencer_if.sv
// ============================================================================
// drive_sequencer_if : control/status bundle between the car's sensing front
//                      end, the drive sequencer and the motor block.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface drive_sequencer_if;
  logic       start;
  logic [1:0] track;
  logic       stop;
  logic [1:0] left;
  logic [1:0] right;
  logic [2:0] speed_mode;
  logic [2:0] fsm_state;
  logic       fault;

  modport master (
    output start, track, stop,
    input  left, right, speed_mode, fsm_state, fault
  );

  modport slave (
    input  start, track, stop,
    output left, right, speed_mode, fsm_state, fault
  );
endinterface

`default_nettype wire

// File: rtl/drive_sequencer.sv
// ============================================================================
// drive_sequencer : registered follow/turn/search/obstacle/halt sequencer that
//                   drives wheel direction codes and motor speed mode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module drive_sequencer #(
  parameter int         MIN_TURN_CYCLES = 100_000,
  parameter int         SEARCH_CYCLES   = 50_000_000,
  parameter int         CLEAR_CYCLES    = 25_000_000,
  parameter logic [2:0] SPD_FAST        = 3'b010,
  parameter logic [2:0] SPD_TURN        = 3'b001,
  parameter logic [2:0] SPD_SLOW        = 3'b000
) (
  input  logic              clk,
  input  logic              rst_n,
  drive_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FOLLOW = 3'd1,
    S_TURN_L = 3'd2,
    S_TURN_R = 3'd3,
    S_SEARCH = 3'd4,
    S_OBST   = 3'd5,
    S_HALT   = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  localparam int HOLD_W   = (MIN_TURN_CYCLES > 1) ? $clog2(MIN_TURN_CYCLES) : 1;
  localparam int SEARCH_W = (SEARCH_CYCLES   > 1) ? $clog2(SEARCH_CYCLES)   : 1;
  localparam int CLR_W    = (CLEAR_CYCLES    > 1) ? $clog2(CLEAR_CYCLES)    : 1;

  localparam logic [HOLD_W-1:0]   C_HOLD_LAST   = HOLD_W'(MIN_TURN_CYCLES - 1);
  localparam logic [SEARCH_W-1:0] C_SEARCH_LAST = SEARCH_W'(SEARCH_CYCLES - 1);
  localparam logic [CLR_W-1:0]    C_CLR_LAST    = CLR_W'(CLEAR_CYCLES - 1);

  localparam logic       C_DIR_LEFT  = 1'b0;
  localparam logic       C_DIR_RIGHT = 1'b1;
  localparam logic [1:0] C_FWD       = 2'b10;
  localparam logic [1:0] C_REV       = 2'b01;
  localparam logic [1:0] C_HOLD      = 2'b00;

  state_t              r_state;
  state_t              w_next;
  logic [HOLD_W-1:0]   r_hold,   w_hold_nxt;
  logic [SEARCH_W-1:0] r_search, w_search_nxt;
  logic [CLR_W-1:0]    r_clr,    w_clr_nxt;
  logic                r_last_dir, w_last_dir_nxt;
  logic [1:0]          r_left,  w_left_nxt;
  logic [1:0]          r_right, w_right_nxt;
  logic [2:0]          r_speed, w_speed_nxt;
  logic                r_fault, w_fault_nxt;

  // Track decode shared by FOLLOW and by a turn that has served its hold time.
  function automatic state_t follow_dest(input logic [1:0] trk);
    case (trk)
      2'b10:   return S_FOLLOW;
      2'b00:   return S_TURN_L;
      2'b01:   return S_TURN_R;
      default: return S_SEARCH;
    endcase
  endfunction

  always_comb begin
    w_next       = r_state;
    w_hold_nxt   = '0;
    w_search_nxt = '0;
    w_clr_nxt    = '0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_FOLLOW;
      end
      S_FOLLOW: begin
        w_next = bus.stop ? S_OBST : follow_dest(bus.track);
      end
      S_TURN_L, S_TURN_R: begin
        if (bus.stop)                    w_next = S_OBST;
        else if (r_hold >= C_HOLD_LAST)  w_next = follow_dest(bus.track);
        else                             w_hold_nxt = r_hold + 1'b1;
      end
      S_SEARCH: begin
        if (bus.stop)                        w_next = S_OBST;
        else if (bus.track != 2'b11)         w_next = S_FOLLOW;
        else if (r_search >= C_SEARCH_LAST)  w_next = S_HALT;
        else                                 w_search_nxt = r_search + 1'b1;
      end
      S_OBST: begin
        // Any obstacle sighting restarts the clear-time run.
        if (bus.stop)                   w_clr_nxt = '0;
        else if (r_clr >= C_CLR_LAST)   w_next = S_FOLLOW;
        else                            w_clr_nxt = r_clr + 1'b1;
      end
      S_HALT: begin
        if (bus.start) w_next = bus.stop ? S_OBST : S_FOLLOW;
      end
      default: w_next = S_IDLE;
    endcase

    w_last_dir_nxt = r_last_dir;
    if (w_next == S_TURN_L) w_last_dir_nxt = C_DIR_LEFT;
    if (w_next == S_TURN_R) w_last_dir_nxt = C_DIR_RIGHT;

    w_left_nxt  = C_HOLD;
    w_right_nxt = C_HOLD;
    w_speed_nxt = SPD_SLOW;
    w_fault_nxt = 1'b0;
    case (w_next)
      S_FOLLOW: begin
        w_left_nxt  = C_FWD;
        w_right_nxt = C_FWD;
        w_speed_nxt = SPD_FAST;
      end
      S_TURN_L: begin
        w_right_nxt = C_FWD;
        w_speed_nxt = SPD_TURN;
      end
      S_TURN_R: begin
        w_left_nxt  = C_FWD;
        w_speed_nxt = SPD_TURN;
      end
      S_SEARCH: begin
        w_left_nxt  = (w_last_dir_nxt == C_DIR_RIGHT) ? C_FWD : C_REV;
        w_right_nxt = (w_last_dir_nxt == C_DIR_RIGHT) ? C_REV : C_FWD;
      end
      S_HALT:  w_fault_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_search   <= '0;
      r_clr      <= '0;
      r_last_dir <= C_DIR_LEFT;
      r_left     <= C_HOLD;
      r_right    <= C_HOLD;
      r_speed    <= SPD_SLOW;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_hold     <= w_hold_nxt;
      r_search   <= w_search_nxt;
      r_clr      <= w_clr_nxt;
      r_last_dir <= w_last_dir_nxt;
      r_left     <= w_left_nxt;
      r_right    <= w_right_nxt;
      r_speed    <= w_speed_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  assign bus.left       = r_left;
  assign bus.right      = r_right;
  assign bus.speed_mode = r_speed;
  assign bus.fsm_state  = r_state;
  assign bus.fault      = r_fault;

endmodule

`default_nettype wire
